// File: rtl/disp_share_arb.sv
// rtl/disp_share_arb.sv - round-robin time-share of one 7-seg digit and LED bank
module disp_share_arb #(
    parameter int   NUM_REQ      = 4,
    parameter int   CLK_IN_MHZ   = 100,
    parameter int   TICK_CYCLES  = CLK_IN_MHZ * 1000,
    parameter int   HOLD_TICKS   = 500,
    parameter logic LED_POLARITY = 1'b1
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   seg_data_i,
    input  logic [8*NUM_REQ-1:0]   led_data_i,
    output logic [NUM_REQ-1:0]     grant_o,
    output logic [7:0]             seg_display_o,
    output logic [7:0]             led_display_o,
    output logic                   busy_o
);
    localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_TICKS);
    localparam logic [IW:0]   NREQ_W   = (IW+1)'(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [7:0]    BLANK    = {8{~LED_POLARITY}};

    typedef enum logic [1:0] {IDLE, OWN, GAP} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [TW-1:0]      tick_q, tick_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic [7:0]         seg_q, seg_d;
    logic [7:0]         led_q, led_d;

    logic [IW-1:0]      win;
    logic [IW:0]        idx;
    logic [7:0]         own_seg, own_led;
    logic [HW-1:0]      hold_inc;
    logic               tick_wrap;
    logic               owner_req;
    logic               others_req;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            tick_q   <= '0;
            hold_q   <= '0;
            seg_q    <= BLANK;
            led_q    <= BLANK;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            tick_q   <= tick_d;
            hold_q   <= hold_d;
            seg_q    <= seg_d;
            led_q    <= led_d;
        end
    end

    // Lowest rotated offset wins, so iterate downward and let later hits overwrite.
    always_comb begin
        win = rr_ptr_q;
        idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = {1'b0, rr_ptr_q} + (IW+1)'(i);
            if (idx >= NREQ_W) idx = idx - NREQ_W;
            if (req_i[idx[IW-1:0]]) win = idx[IW-1:0];
        end
    end

    always_comb begin
        own_seg = '0;
        own_led = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == IW'(k)) begin
                own_seg = seg_data_i[8*k +: 8];
                own_led = led_data_i[8*k +: 8];
            end
        end
    end

    // hold_inc is the hold count after this edge; preempting on it makes the
    // ownership exactly HOLD_TICKS*TICK_CYCLES cycles long.
    always_comb begin
        tick_wrap  = (tick_q == TICK_MAX);
        hold_inc   = (tick_wrap && hold_q != HOLD_MAX) ? hold_q + 1'b1 : hold_q;
        owner_req  = |(req_i & grant_q);
        others_req = |(req_i & ~grant_q);
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        tick_d     = tick_q;
        hold_d     = hold_q;
        case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = OWN;
                    owner_d = win;
                    tick_d  = '0;
                    hold_d  = '0;
                end
            end
            OWN: begin
                tick_d = tick_wrap ? '0 : tick_q + 1'b1;
                hold_d = hold_inc;
                if (!owner_req || (hold_inc == HOLD_MAX && others_req)) begin
                    state_d  = GAP;
                    rr_ptr_d = (owner_q == LAST_IDX) ? '0 : owner_q + 1'b1;
                end
            end
            GAP:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        grant_d = '0;
        seg_d   = BLANK;
        led_d   = BLANK;
        if (state_q == IDLE && |req_i) begin
            grant_d = NUM_REQ'(1) << win;
        end else if (state_q == OWN && state_d == OWN) begin
            grant_d = grant_q;
            seg_d   = LED_POLARITY ? own_seg : ~own_seg;
            led_d   = LED_POLARITY ? own_led : ~own_led;
        end
    end

    assign grant_o       = grant_q;
    assign busy_o        = |grant_q;
    assign seg_display_o = seg_q;
    assign led_display_o = led_q;
endmodule

// File: doc/disp_share_arb.md
Name: disp_share_arb

Overview:
Time-shares the board's single seven-segment digit and 8-bit LED bank between up to NUM_REQ display requesters (e.g. counter demo, self-test status, error codes) using a request/grant handshake. Arbitration is round-robin with a minimum ownership time, so each owner's pattern is visible for a readable interval. A one-cycle blank gap separates owners. Sits between the display sources and the board output pins, downstream of the reset synchroniser.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
CLK_IN_MHZ, 100, input clock frequency in MHz.
TICK_CYCLES, CLK_IN_MHZ*1000, clock cycles per ownership tick (nominally 1 ms); overridden small in simulation.
HOLD_TICKS, 500, minimum ownership in ticks before preemption (>=1).
LED_POLARITY, 1'b1, active level of the board outputs; 1 = active-high.

Ports:
clk_i  in  1  system clock
rstn_i  in  1  reset, asynchronous, active-low
req_i  in  NUM_REQ  per-requester display request, level
seg_data_i  in  8*NUM_REQ  segment pattern per requester, slice k = [8k+7:8k], active-high
led_data_i  in  8*NUM_REQ  LED pattern per requester, same slicing, active-high
grant_o  out  NUM_REQ  one-hot grant, zero when no owner
seg_display_o  out  8  segment drive to board pins
led_display_o  out  8  LED drive to board pins
busy_o  out  1  high while any grant is asserted

Behaviour:
- Output polarity: driven = LED_POLARITY ? data : ~data. Blank = 8{~LED_POLARITY}, i.e. all segments/LEDs off.
- Reset (async assert, any state): state IDLE; grant_o = 0; busy_o = 0; seg_display_o = led_display_o = blank; rr_ptr = 0; hold and tick counters = 0. Effect is immediate, including mid-ownership. Reset release is already synchronous to clk_i upstream.
- States: IDLE, OWN, GAP.
- IDLE:
  - Outputs blank.
  - If any req_i is set, select the first set bit searching upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NUM_REQ-1, 0, ...).
  - Next edge: grant_o one-hot for the winner, busy_o = 1, enter OWN, clear tick and hold counters.
  - Latency: req_i high at edge T gives grant_o high after edge T+1.
- OWN:
  - seg_display_o and led_display_o register the owner's slices every cycle, so outputs follow the owner's data with 1-cycle latency. The first valid pattern appears one cycle after grant_o rises.
  - The tick counter counts 0..TICK_CYCLES-1 and wraps. Each wrap increments the hold counter, which saturates at HOLD_TICKS.
  - Owner drops req: enter GAP next edge, regardless of the hold count.
  - Hold counter == HOLD_TICKS and another req_i bit is set: enter GAP.
  - Hold counter == HOLD_TICKS and no other request: remain in OWN indefinitely; the counter stays saturated.
  - Minimum ownership before preemption: exactly HOLD_TICKS*TICK_CYCLES cycles measured from the grant edge.
- GAP (exactly 1 cycle):
  - grant_o = 0, busy_o = 0, outputs blank.
  - rr_ptr = (owner+1) mod NUM_REQ.
  - Return to IDLE. A pending request is granted after 1 further cycle, so grant_o is low for 2 cycles between owners.
- Data on non-granted slices is ignored. req_i changes during GAP/IDLE are sampled only in IDLE.
- Simultaneous events: if the owner drops req on the same edge the hold expires, treat it as a drop; rr_ptr advances identically either way.
- Invariants: grant_o is always zero or one-hot; busy_o == |grant_o.
- Counter widths: $clog2(TICK_CYCLES) and $clog2(HOLD_TICKS+1) bits, no overflow.

Test Plan:
All scenarios use NUM_REQ=4, TICK_CYCLES=10, HOLD_TICKS=3 (hold = 30 cycles), LED_POLARITY=1, unless stated otherwise.
1. Reset: rstn_i low with req_i=4'b1111 -> grant_o=0, seg/led=8'h00, busy_o=0. Release, req_i[2] only -> grant_o=4'b0100 one cycle later; seg_display_o = seg_data_i[23:16] one cycle after that.
2. Round-robin: req_i=4'b1111 held -> grants in order 0,1,2,3,0, each held exactly 30 cycles. Each handoff has 2 cycles of grant_o=0 and blank outputs.
3. Early release: req0 granted, req0 dropped at cycle 5 of ownership while req3 is pending -> GAP next edge, then grant_o=4'b1000; rr_ptr advanced to 1.
4. Sole owner: req1 alone for 200 cycles -> grant_o stays 4'b0010 throughout. Asserting req0 at cycle 150 -> GAP next edge, then grant_o=4'b0001.
5. Mid-ownership reset: assert rstn_i low at cycle 12 of an ownership -> outputs blank and grant_o=0 with no clock edge. After release with req_i=4'b0110 -> grant_o=4'b0010, since rr_ptr has reset to 0.
6. Polarity: LED_POLARITY=0, owner seg_data=8'hA5 -> seg_display_o=8'h5A; IDLE/GAP -> 8'hFF.
